// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/D memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam logic [3:0]  WEN_READ = 4'b0000;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_D    = 2'd2
  } rsp_state_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles in which a pending IF request was
// denied. o_force asserts once the count reaches MAX_STARVE.
module arb_starve_ctr #(
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_if_req,
  input  logic i_if_gnt,
  output logic o_force
);

  localparam logic [3:0] LP_MAX = 4'(MAX_STARVE);

  logic [3:0] r_cnt;

  // Count denied IF cycles, clear on grant or idle, hold at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_if_req || i_if_gnt) begin
      r_cnt <= '0;
    end else if (r_cnt != LP_MAX) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_force = (r_cnt == LP_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous memory between the fetch (IF) and
// load/store (D) ports. D wins conflicts unless IF has been starved.
// Optional build macro: MEM_ARB_PERF_EN adds perf_conflicts / perf_forced.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_wen,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_conflicts,
  output logic [15:0]       perf_forced
`endif
);

  rsp_state_e r_state;
  logic       w_force;
  logic       w_if_gnt;
  logic       w_d_gnt;
  logic       w_unused_addr;

  arb_starve_ctr #(
    .MAX_STARVE (MAX_STARVE)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .i_if_req (if_req),
    .i_if_gnt (w_if_gnt),
    .o_force  (w_force)
  );

  // Byte-offset bits and bits above the memory size alias away.
  assign w_unused_addr = ^{if_addr[DATA_W-1:ADDR_W+2], if_addr[1:0],
                           d_addr[DATA_W-1:ADDR_W+2], d_addr[1:0]};

  // Grant: D has priority unless the starvation counter forces IF.
  always_comb begin
    w_if_gnt = 1'b0;
    w_d_gnt  = 1'b0;
    if (!rst) begin
      w_if_gnt = if_req && (!d_req || w_force);
      w_d_gnt  = d_req && !w_if_gnt;
    end
  end

  assign if_gnt = w_if_gnt;
  assign d_gnt  = w_d_gnt;
  assign mem_en = w_if_gnt | w_d_gnt;

  // Memory request mux; all fields zero when nothing is granted.
  always_comb begin
    mem_wen   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_if_gnt) begin
      mem_addr = if_addr[ADDR_W+1:2];
    end else if (w_d_gnt) begin
      mem_wen   = d_wen;
      mem_addr  = d_addr[ADDR_W+1:2];
      mem_wdata = d_wdata;
    end
  end

  // Response FSM: remembers which port owns next cycle's read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RSP_NONE;
    end else if (w_if_gnt) begin
      r_state <= RSP_IF;
    end else if (w_d_gnt && (d_wen == WEN_READ)) begin
      r_state <= RSP_D;
    end else begin
      r_state <= RSP_NONE;
    end
  end

  // rst also masks the response combinationally so an in-flight read is
  // dropped in the very cycle reset is asserted.
  always_comb begin
    if_rvalid = !rst && (r_state == RSP_IF);
    d_rvalid  = !rst && (r_state == RSP_D);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid  ? mem_rdata : '0;
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] r_perf_conflicts;
  logic [15:0] r_perf_forced;

  // Conflict cycles wrap; forced IF grants saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_conflicts <= '0;
      r_perf_forced    <= '0;
    end else begin
      if (if_req && d_req) begin
        r_perf_conflicts <= r_perf_conflicts + 32'd1;
      end
      if (w_if_gnt && d_req && (r_perf_forced != '1)) begin
        r_perf_forced <= r_perf_forced + 16'd1;
      end
    end
  end

  assign perf_conflicts = r_perf_conflicts;
  assign perf_forced    = r_perf_forced;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a reference model of the arbitration
// rules and a behavioural memory attached to the mem_* bus.
module tb_mem_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned MS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          d_req;
  logic [3:0]    d_wen;
  logic [31:0]   d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          mem_en;
  logic [3:0]    mem_wen;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]   perf_conflicts;
  logic [15:0]   perf_forced;
`endif

  int n_checks = 0;
  int n_err    = 0;

  mem_arbiter #(
    .ADDR_W     (AW),
    .MAX_STARVE (MS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_wen     (d_wen),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_conflicts (perf_conflicts),
    .perf_forced    (perf_forced)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] preload(input int i);
    case (i)
      0:       return 32'h00500313;
      1:       return 32'h008000EF;
      2:       return 32'h00A30313;
      3:       return 32'h11112222;
      'h40:    return 32'hDEADBEEF;
      'h41:    return 32'hCAFEF00D;
      default: return 32'h0;
    endcase
  endfunction

  // Behavioural write-first synchronous memory on the arbiter's memory bus.
  logic [31:0] pmem [0:1023];
  bit          p_init = 1'b0;
  always @(posedge clk) begin
    if (!p_init) begin
      for (int i = 0; i < 1024; i++) pmem[i] <= preload(i);
      mem_rdata <= 32'h0;
      p_init    <= 1'b1;
    end else if (mem_en) begin
      if (mem_wen == 4'b0000) begin
        mem_rdata <= pmem[mem_addr];
      end else begin
        for (int b = 0; b < 4; b++)
          if (mem_wen[b]) pmem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Reference model: evaluated between edges from the current requests and
  // the model's own history, then advanced to the next cycle.
  logic [31:0] gm [0:1023];
  int          m_n = 0;
  int          m_denied;
  bit          m_pend_if, m_pend_d;
  logic [31:0] m_pend_data;
  logic [31:0] m_conf;
  int          m_forced;

  always @(negedge clk) begin
    bit          e_ig, e_dg, e_ivld, e_dvld;
    int          wi, wd;
    logic [31:0] e_maddr, e_mwdata;
    logic [3:0]  e_mwen;
    if (m_n == 0) begin
      for (int i = 0; i < 1024; i++) gm[i] = preload(i);
      m_denied = 0; m_pend_if = 0; m_pend_d = 0; m_pend_data = 0;
      m_conf = 0; m_forced = 0;
    end
    wi = int'(if_addr / 4) % 1024;
    wd = int'(d_addr / 4) % 1024;
    e_ig = !rst && if_req && (!d_req || m_denied >= MS);
    e_dg = !rst && d_req && !e_ig;
    e_ivld = !rst && m_pend_if;
    e_dvld = !rst && m_pend_d;
    e_maddr = e_ig ? 32'(wi) : (e_dg ? 32'(wd) : 32'h0);
    e_mwdata = e_dg ? d_wdata : 32'h0;
    e_mwen = e_dg ? d_wen : 4'h0;
    if (m_n > 0) begin
      check("if_gnt", {31'h0, if_gnt}, {31'h0, e_ig});
      check("d_gnt", {31'h0, d_gnt}, {31'h0, e_dg});
      check("mem_en", {31'h0, mem_en}, {31'h0, e_ig | e_dg});
      check("mem_wen", {28'h0, mem_wen}, {28'h0, e_mwen});
      check("mem_addr", 32'(mem_addr), e_maddr);
      check("mem_wdata", mem_wdata, e_mwdata);
      check("if_rvalid", {31'h0, if_rvalid}, {31'h0, e_ivld});
      check("d_rvalid", {31'h0, d_rvalid}, {31'h0, e_dvld});
      check("if_rdata", if_rdata, e_ivld ? m_pend_data : 32'h0);
      check("d_rdata", d_rdata, e_dvld ? m_pend_data : 32'h0);
`ifdef MEM_ARB_PERF_EN
      check("perf_conflicts", perf_conflicts, m_conf);
      check("perf_forced", {16'h0, perf_forced}, 32'(m_forced));
`endif
    end
    if (rst) begin
      m_denied = 0; m_pend_if = 0; m_pend_d = 0;
      m_conf = 0; m_forced = 0;
    end else begin
      if (if_req && d_req) m_conf = m_conf + 1;
      if (e_ig && d_req && m_forced < 65535) m_forced++;
      if (if_req && !e_ig) m_denied = (m_denied < MS) ? m_denied + 1 : MS;
      else m_denied = 0;
      m_pend_if = e_ig;
      m_pend_d = e_dg && (d_wen == 4'b0000);
      if (e_ig) m_pend_data = gm[wi];
      else if (e_dg) m_pend_data = gm[wd];
      if (e_dg) for (int b = 0; b < 4; b++)
        if (d_wen[b]) gm[wd][8*b +: 8] = d_wdata[8*b +: 8];
    end
    m_n++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 0; d_req = 0; d_wen = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_if [0:2];
    logic [5:0]  gpat;
    exp_if[0] = 32'h00500313; exp_if[1] = 32'h008000EF; exp_if[2] = 32'h00A30313;

    // Reset with both ports requesting: nothing may be granted.
    rst = 1; idle(); if_req = 1; d_req = 1; d_addr = 32'h100;
    repeat (3) tick();
    @(negedge clk);
    check("rst_if_gnt", {31'h0, if_gnt}, 32'h0);
    check("rst_d_gnt", {31'h0, d_gnt}, 32'h0);
    check("rst_mem_en", {31'h0, mem_en}, 32'h0);
    tick(); rst = 0; idle();

    // 1. IF-only streaming.
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin if_req = 1; if_addr = 32'(4 * i); end
      else if_req = 0;
      @(negedge clk);
      if (i < 3) check("t1_if_gnt", {31'h0, if_gnt}, 32'h1);
      if (i > 0) begin
        check("t1_if_rvalid", {31'h0, if_rvalid}, 32'h1);
        check("t1_if_rdata", if_rdata, exp_if[i-1]);
        check("t1_d_rvalid", {31'h0, d_rvalid}, 32'h0);
      end
      tick();
    end

    // 2. Conflict: D wins, IF follows.
    if_req = 1; if_addr = 32'h0C; d_req = 1; d_wen = 0; d_addr = 32'h100;
    @(negedge clk);
    check("t2_d_gnt", {31'h0, d_gnt}, 32'h1);
    check("t2_if_gnt", {31'h0, if_gnt}, 32'h0);
    tick(); d_req = 0;
    @(negedge clk);
    check("t2_d_rvalid", {31'h0, d_rvalid}, 32'h1);
    check("t2_d_rdata", d_rdata, 32'hDEADBEEF);
    check("t2_if_gnt_next", {31'h0, if_gnt}, 32'h1);
    tick(); if_req = 0;
    @(negedge clk);
    check("t2_if_rdata", if_rdata, 32'h11112222);
    tick();

    // 3. Starvation: six conflict cycles.
    if_req = 1; if_addr = 0; d_req = 1; d_wen = 0; d_addr = 32'h104;
    gpat = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      gpat[i] = if_gnt;
      check("t3_one_gnt", {30'h0, if_gnt, d_gnt}, {30'h0, if_gnt, ~if_gnt});
      tick();
    end
    check("t3_if_pattern", {26'h0, gpat}, 32'h10);
    idle();
    tick();

    // 4. Write then read, then a partial write through an aliased address.
    d_req = 1; d_wen = 4'hF; d_addr = 32'h40; d_wdata = 32'h12345678;
    @(negedge clk);
    check("t4_wr_gnt", {31'h0, d_gnt}, 32'h1);
    check("t4_mem_wen", {28'h0, mem_wen}, 32'hF);
    tick(); d_wen = 0; d_wdata = 0;
    @(negedge clk);
    check("t4_no_wr_rvalid", {31'h0, d_rvalid}, 32'h0);
    tick(); d_req = 0;
    @(negedge clk);
    check("t4_rd_data", d_rdata, 32'h12345678);
    tick();
    d_req = 1; d_wen = 4'b0011; d_addr = 32'h1040; d_wdata = 32'hAAAABBBB;
    @(negedge clk);
    check("t4_alias_addr", 32'(mem_addr), 32'h10);
    tick(); d_wen = 0; d_addr = 32'h40; d_wdata = 0;
    tick(); d_req = 0;
    @(negedge clk);
    check("t4_partial_data", d_rdata, 32'h1234BBBB);
    tick();

    // 5a. Reset the cycle after an IF grant: that response is dropped.
    if_req = 1; if_addr = 32'h8;
    @(negedge clk);
    check("t5_if_gnt", {31'h0, if_gnt}, 32'h1);
    tick(); rst = 1;
    @(negedge clk);
    check("t5_rst_rvalid", {31'h0, if_rvalid}, 32'h0);
    check("t5_rst_rdata", if_rdata, 32'h0);
    tick(); rst = 0;
    @(negedge clk);
    check("t5_post_gnt", {31'h0, if_gnt}, 32'h1);
    check("t5_post_rvalid", {31'h0, if_rvalid}, 32'h0);
    tick(); if_req = 0;
    @(negedge clk);
    check("t5_post_rdata", if_rdata, 32'h00A30313);
    tick();

    // 5b. Reset clears a part-built starvation count.
    if_req = 1; if_addr = 0; d_req = 1; d_wen = 0; d_addr = 32'h104;
    repeat (3) tick();
    rst = 1;
    @(negedge clk);
    check("t5_rst_d_rvalid", {31'h0, d_rvalid}, 32'h0);
    check("t5_rst_mem_en", {31'h0, mem_en}, 32'h0);
    tick(); tick(); rst = 0;
    gpat = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      gpat[i] = if_gnt;
      tick();
    end
    check("t5_starve_cleared", {26'h0, gpat}, 32'h10);
    idle();
    tick();

`ifdef MEM_ARB_PERF_EN
    // 6. Performance counters over ten conflict cycles.
    rst = 1; tick(); rst = 0;
    if_req = 1; d_req = 1; d_wen = 0; d_addr = 32'h100;
    repeat (10) tick();
    idle();
    @(negedge clk);
    check("t6_perf_conflicts", perf_conflicts, 32'd10);
    check("t6_perf_forced", {16'h0, perf_forced}, 32'd2);
    tick();
`endif

    tick();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one synchronous single-port 32-bit memory between the CPU fetch port (IF) and the load/store port (D). Each cycle it grants at most one port and drives the memory. It routes read data back to the owning port one cycle later. Data accesses win conflicts unless an anti-starvation counter forces an IF grant. Sits between cpu_top's i_mem_*/d_mem_* buses and the unified memory macro.

Parameters:
ADDR_W, 10, memory word-address width (1024 words)
MAX_STARVE, 4, consecutive denied IF-request cycles before IF gets forced priority (1..15)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request
if_addr  in  32  fetch byte address; bits [1:0] ignored
if_gnt  out  1  fetch accepted this cycle
if_rvalid  out  1  if_rdata valid; one cycle after if_gnt
if_rdata  out  32  fetch data
d_req  in  1  data request
d_wen  in  4  byte write enables; 4'b0000 = read
d_addr  in  32  data byte address; bits [1:0] ignored
d_wdata  in  32  write data
d_gnt  out  1  data access accepted this cycle
d_rvalid  out  1  d_rdata valid; one cycle after a read grant
d_rdata  out  32  load data
mem_en  out  1  memory access strobe
mem_wen  out  4  memory byte write enables
mem_addr  out  ADDR_W  word address = granted addr[ADDR_W+1:2]
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data; valid the cycle after mem_en with mem_wen=0

Behaviour:
- Grant is combinational from the requests and registered state. A requester holds req/addr/wdata stable until it sees gnt.
- Grant rule:
  - Only one port requesting: that port is granted.
  - Both requesting: D is granted, unless starve_cnt == MAX_STARVE, in which case IF is granted.
- starve_cnt (4-bit register):
  - increments when if_req=1 and if_gnt=0;
  - clears when if_gnt=1 or if_req=0;
  - saturates at MAX_STARVE.
- Memory outputs:
  - mem_en = if_gnt | d_gnt.
  - mem_wen = d_wen when d_gnt=1, else 0.
  - mem_addr and mem_wdata come from the granted port.
  - When mem_en=0, mem_addr and mem_wdata are 0.
- Response FSM, registered, states RSP_NONE / RSP_IF / RSP_D:
  - Next state is RSP_IF if if_gnt; RSP_D if d_gnt and d_wen==0; otherwise RSP_NONE.
  - Writes produce no response.
- Responses:
  - if_rvalid = (state==RSP_IF); d_rvalid = (state==RSP_D).
  - rdata is mem_rdata when the matching rvalid is set, else 0.
  - Back-to-back grants give one response per cycle, throughput 1 access/cycle.
- Reset: state=RSP_NONE, starve_cnt=0. All outputs read 0 in the cycle after reset asserts. rst takes effect mid-operation: a pending response is dropped and no rvalid follows.
- No request during rst=1 is granted: gnt forced 0 and mem_en=0.
- Write followed by read of the same address on the next cycle returns the new data; the memory is write-first.
- Address bits above ADDR_W+1 are ignored (wrap-around aliasing).

Optional Feature:
MEM_ARB_PERF_EN
- Defined:
  - Adds output perf_conflicts (32): counts cycles with if_req & d_req, wraps at 2^32, cleared by rst.
  - Adds output perf_forced (16): counts starvation-forced IF grants, saturates at 16'hFFFF, cleared by rst.
- Undefined: ports and counters absent; arbitration behaviour identical.

Decomposition:
- Package mem_arb_pkg:
  - rsp_state_e enum (RSP_NONE=2'd0, RSP_IF=2'd1, RSP_D=2'd2);
  - constant WEN_READ=4'b0000;
  - DATA_W=32.
- One natural sub-module, arb_starve_ctr: the saturating starvation counter with force output. The remaining grant/mux/FSM logic stays in mem_arbiter.

Test Plan:
1. IF-only streaming: if_req=1, addresses 0x00, 0x04, 0x08 on consecutive cycles, memory preloaded 0x00500313, 0x008000EF, 0x00A30313 -> if_gnt=1 every cycle; if_rvalid with those words on cycles 1, 2, 3; d_* outputs 0.
2. Conflict with data priority: if_req and d_req (read, 0x100 holding 0xDEADBEEF) both high for 1 cycle -> d_gnt=1, if_gnt=0; next cycle d_rvalid=1, d_rdata=0xDEADBEEF; IF granted the following cycle.
3. Starvation, MAX_STARVE=4: if_req and d_req held high 6 cycles -> d_gnt in cycles 0-3, if_gnt in cycle 4, d_gnt in cycle 5.
4. Write then read: D write 0x12345678, wen=4'b1111, addr 0x40; then read 0x40 -> no rvalid after the write; d_rvalid with 0x12345678 one cycle after the read grant.
5. Reset mid-operation: assert rst the cycle after an IF grant -> if_rvalid stays 0; starve_cnt=0; all outputs 0 while rst=1; normal grant the cycle after rst deasserts.
6. MEM_ARB_PERF_EN: 10 conflict cycles with MAX_STARVE=4 -> perf_conflicts=10, perf_forced=2.
